// File: rtl/seq_shift_unit.sv
// Multi-mode sequential shift register for the shift-add multiplier datapath.
// Executes a logical, arithmetic or rotate shift one bit per clock under a start/busy/done handshake.
module seq_shift_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [AMT_W-1:0] i_amt,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_sin,
   output logic [WIDTH-1:0] o_out,
   output logic             o_sout,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   logic [AMT_W-1:0]   r_count;
   logic [2:0]         r_op;
   logic [WIDTH-1:0]   r_out;
   logic               r_sout;
   logic               r_busy;
   logic               r_done;

   state_t             w_state_nxt;
   logic [AMT_W-1:0]   w_count_nxt;
   logic [2:0]         w_op_nxt;
   logic [WIDTH-1:0]   w_out_nxt;
   logic               w_sout_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;

   logic [WIDTH-1:0]   w_step_out;
   logic               w_step_sout;

   // Single-bit shift result for the captured mode; reserved modes hold.
   always_comb begin
      w_step_out  = r_out;
      w_step_sout = r_sout;
      case (r_op)
         OP_SLL: begin
            w_step_out  = {r_out[WIDTH-2:0], i_sin};
            w_step_sout = r_out[WIDTH-1];
         end
         OP_SRL: begin
            w_step_out  = {i_sin, r_out[WIDTH-1:1]};
            w_step_sout = r_out[0];
         end
         OP_SRA: begin
            w_step_out  = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
            w_step_sout = r_out[0];
         end
         OP_ROL: begin
            w_step_out  = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
            w_step_sout = r_out[WIDTH-1];
         end
         OP_ROR: begin
            w_step_out  = {r_out[0], r_out[WIDTH-1:1]};
            w_step_sout = r_out[0];
         end
         default: begin
            w_step_out  = r_out;
            w_step_sout = r_sout;
         end
      endcase
   end

   // Next-state and datapath update; load wins over start in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_op_nxt    = r_op;
      w_out_nxt   = r_out;
      w_sout_nxt  = r_sout;
      w_done_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_load) begin
               w_out_nxt = i_din;
            end else if (i_start) begin
               w_op_nxt = i_op;
               if (i_amt == AMT_W'(0)) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_count_nxt = i_amt;
                  w_state_nxt = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            w_out_nxt   = w_step_out;
            w_sout_nxt  = w_step_sout;
            w_count_nxt = r_count - AMT_W'(1);
            if (r_count == AMT_W'(1)) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == ST_SHIFT);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_op    <= '0;
         r_out   <= '0;
         r_sout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_op    <= w_op_nxt;
         r_out   <= w_out_nxt;
         r_sout  <= w_sout_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign o_out  = r_out;
   assign o_sout = r_sout;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed plus randomized bench for seq_shift_unit at WIDTH=8, AMT_W=4.
// Expected values come from an arithmetic shift model of each command.
module tb_seq_shift_unit;

   localparam int unsigned W  = 8;
   localparam int unsigned AW = 4;

   logic          clk;
   logic          rst;
   logic          load;
   logic          start;
   logic [2:0]    op;
   logic [AW-1:0] amt;
   logic [W-1:0]  din;
   logic          sin;
   logic [W-1:0]  out;
   logic          sout;
   logic          busy;
   logic          done;

   int n_vec;
   int n_err;
   int m_out;
   int m_sout;

   seq_shift_unit #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_load  (load),
      .i_start (start),
      .i_op    (op),
      .i_amt   (amt),
      .i_din   (din),
      .i_sin   (sin),
      .o_out   (out),
      .o_sout  (sout),
      .o_busy  (busy),
      .o_done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input int busy_e, input int done_e);
      chk({tag, "_out"},  32'(out),  32'(m_out));
      chk({tag, "_sout"}, 32'(sout), 32'(m_sout));
      chk({tag, "_busy"}, 32'(busy), 32'(busy_e));
      chk({tag, "_done"}, 32'(done), 32'(done_e));
   endtask

   // One shift step in plain arithmetic on an 8-bit value.
   task automatic model_step(input int o, input int s);
      int v;
      v = m_out;
      case (o)
         0: begin m_out = (v * 2 + s) % 256;          m_sout = v / 128; end
         1: begin m_out = v / 2 + s * 128;            m_sout = v % 2;   end
         2: begin m_out = v / 2 + ((v >= 128) ? 128 : 0); m_sout = v % 2; end
         3: begin m_out = (v * 2) % 256 + v / 128;    m_sout = v / 128; end
         4: begin m_out = v / 2 + (v % 2) * 128;      m_sout = v % 2;   end
         default: ;
      endcase
   endtask

   task automatic do_load(input int d);
      load  = 1'b1;
      start = 1'b0;
      din   = W'(d);
      tick();
      load  = 1'b0;
      m_out = d % 256;
      check_state("load", 0, 0);
   endtask

   // Issues a command and follows it cycle by cycle; sin_mode 0/1 fixed, 2 random.
   task automatic run_cmd(input int o, input int a, input int sin_mode, input bit noise);
      int s;
      op    = 3'(o);
      amt   = AW'(a);
      start = 1'b1;
      load  = 1'b0;
      tick();
      start = 1'b0;
      if (a == 0) begin
         check_state("cmd0", 0, 1);
         return;
      end
      for (int k = 1; k <= a; k++) begin
         check_state("shift", 1, 0);
         s   = (sin_mode == 2) ? int'($urandom_range(0, 1)) : sin_mode;
         sin = 1'(s);
         if (noise) begin
            load  = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            din   = W'($urandom);
            op    = 3'($urandom);
            amt   = AW'($urandom);
         end
         model_step(o, s);
         tick();
      end
      load  = 1'b0;
      start = 1'b0;
      check_state("done", 0, 1);
   endtask

   task automatic idle_check();
      load  = 1'b0;
      start = 1'b0;
      tick();
      check_state("idle", 0, 0);
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      m_out  = 0;
      m_sout = 0;

      // Reset with load asserted must leave everything clear.
      rst   = 1'b0;
      load  = 1'b1;
      start = 1'b0;
      din   = 8'hFF;
      op    = 3'd0;
      amt   = '0;
      sin   = 1'b0;
      tick();
      tick();
      check_state("reset", 0, 0);
      rst  = 1'b1;
      load = 1'b0;
      tick();
      check_state("post_reset", 0, 0);

      // SLL by 3 with sin=1.
      do_load(8'hB4);
      run_cmd(0, 3, 1, 1'b0);
      chk("s2_const", 32'(out), 32'h0000_00A7);
      idle_check();

      // SRA by 2 then ROR by 9 (wraps past WIDTH).
      do_load(8'h96);
      run_cmd(2, 2, 0, 1'b0);
      chk("s3_sra_const", 32'(out), 32'h0000_00E5);
      idle_check();
      run_cmd(4, 9, 0, 1'b0);
      chk("s3_ror_const", 32'(out), 32'h0000_00F2);
      idle_check();

      // Zero-length command and a reserved op.
      run_cmd(1, 0, 0, 1'b0);
      idle_check();
      run_cmd(6, 4, 2, 1'b0);
      idle_check();

      // ROL by 5 with load/start noise during the shift.
      do_load(8'h5C);
      run_cmd(3, 5, 2, 1'b1);
      chk("s5_const", 32'(out), 32'h0000_008B);
      idle_check();

      // Reset on the third shift edge aborts without done.
      op    = 3'd3;
      amt   = AW'(5);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check_state("abort_shift", 1, 0);
         model_step(3, 0);
         tick();
      end
      rst    = 1'b0;
      tick();
      m_out  = 0;
      m_sout = 0;
      check_state("abort", 0, 0);
      rst = 1'b1;
      idle_check();
      idle_check();

      // Load and start together: only the load happens.
      load  = 1'b1;
      start = 1'b1;
      din   = 8'h3C;
      op    = 3'd0;
      amt   = AW'(4);
      tick();
      load  = 1'b0;
      start = 1'b0;
      m_out = 8'h3C;
      check_state("load_start", 0, 0);
      idle_check();

      // Start in the done cycle is accepted back to back.
      run_cmd(1, 2, 1, 1'b0);
      run_cmd(0, 3, 0, 1'b0);
      run_cmd(2, 0, 0, 1'b0);
      run_cmd(4, 1, 0, 1'b0);
      idle_check();

      // Randomized command stream.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) do_load(int'($urandom_range(0, 255)));
         run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 2,
                 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) != 0) idle_check();
      end
      idle_check();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
